ahb_bus_arbiter: RTL and testbench

Bus arbiter for the shared AHB-Lite fabric: it grants the single address/data bus to one of up to 16 masters, such as the CPU, a DMA or a test master. It then publishes the owning master to the slave-select decoder and the slave multiplexers. Fixed-length bursts and locked sequences are never broken, and with no requests the bus parks on a default master. The arbiter sits between the master request lines and the address/control multiplexer feeding the decoder.

---
 rtl/ahb_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - AHB-Lite bus arbiter: round-robin grant, burst/lock protection, default-master parking
// Build macro ARB_FIXED_PRIORITY_EN switches selection to fixed priority (lowest requesting index wins).
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [3:0]             HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    typedef enum logic {ARB, BURST} state_t;

    state_t                   state, state_nxt;
    logic [3:0]               cnt, cnt_nxt;
    logic [3:0]               grant_idx;
    logic [3:0]               sel_idx;
    logic                     lock_cur;
    logic                     rearb;
    logic [NUM_MASTERS-1:0]   grant_nxt;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (HGRANT[i]) grant_idx = 4'(i);
        end
    end

    assign lock_cur = |(HLOCK & HGRANT);

`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        sel_idx = 4'(DEFAULT_MASTER);
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (HBUSREQ[i]) sel_idx = 4'(i);
        end
    end
`else
    logic       hi_found, lo_found;
    logic [3:0] hi_idx, lo_idx;

    // Wrap-around scan split in two: indices above the grantee first, then
    // 0..grantee, so the current owner is considered last.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (HBUSREQ[i] && (4'(i) > grant_idx)) begin
                hi_found = 1'b1;
                hi_idx   = 4'(i);
            end
            if (HBUSREQ[i] && (4'(i) <= grant_idx)) begin
                lo_found = 1'b1;
                lo_idx   = 4'(i);
            end
        end
        if (hi_found)      sel_idx = hi_idx;
        else if (lo_found) sel_idx = lo_idx;
        else               sel_idx = 4'(DEFAULT_MASTER);
    end
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rearb     = 1'b0;
        case (state)
            ARB: begin
                if (HTRANS == TR_NONSEQ && HBURST >= 3'd2) begin
                    state_nxt = BURST;
                    case (HBURST)
                        3'd2, 3'd3: cnt_nxt = 4'd3;
                        3'd4, 3'd5: cnt_nxt = 4'd7;
                        default:    cnt_nxt = 4'd15;
                    endcase
                end else begin
                    rearb = 1'b1;
                end
            end
            BURST: begin
                case (HTRANS)
                    TR_SEQ: begin
                        // cnt holds the SEQ beats still owed; the last one ends the burst
                        if (cnt <= 4'd1) begin
                            state_nxt = ARB;
                            cnt_nxt   = '0;
                            rearb     = 1'b1;
                        end else begin
                            cnt_nxt = cnt - 4'd1;
                        end
                    end
                    TR_BUSY: ;
                    default: begin
                        state_nxt = ARB;
                        cnt_nxt   = '0;
                        rearb     = 1'b1;
                    end
                endcase
            end
            default: begin
                state_nxt = ARB;
                cnt_nxt   = '0;
            end
        endcase

        grant_nxt = HGRANT;
        if (rearb && !lock_cur) grant_nxt = NUM_MASTERS'(1) << sel_idx;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ARB;
            cnt       <= '0;
            HGRANT    <= NUM_MASTERS'(1) << DEFAULT_MASTER;
            HMASTER   <= 4'(DEFAULT_MASTER);
            HMASTLOCK <= 1'b0;
        end else if (HREADY) begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            HGRANT    <= grant_nxt;
            HMASTER   <= grant_idx;
            HMASTLOCK <= lock_cur;
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb/tb_ahb_bus_arbiter.sv - self-checking bench for ahb_bus_arbiter against a transaction-level model
module tb_ahb_bus_arbiter;
    localparam int N  = 3;
    localparam int DM = 0;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] hbusreq, hlock;
    logic [1:0]   htrans;
    logic [2:0]   hburst;
    logic         hready;
    logic [N-1:0] hgrant;
    logic [3:0]   hmaster;
    logic         hmastlock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: owner, published master/lock, whether a fixed burst is running
    // and how many SEQ beats it still owes.
    int m_grant, m_master, m_rem;
    bit m_lock, m_burst;

    always #5 clk = ~clk;

    ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DM)) dut (
        .HCLK(clk), .HRESET(rst), .HBUSREQ(hbusreq), .HLOCK(hlock),
        .HTRANS(htrans), .HBURST(hburst), .HREADY(hready),
        .HGRANT(hgrant), .HMASTER(hmaster), .HMASTLOCK(hmastlock)
    );

    function automatic int pick(input logic [N-1:0] req, input int g);
        int best = -1;
        int bestd = N;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = N - 1; i >= 0; i--) if (req[i]) best = i;
`else
        for (int i = 0; i < N; i++) begin
            int d = (i - g - 1 + N) % N;
            if (req[i] && d < bestd) begin
                bestd = d;
                best = i;
            end
        end
`endif
        return (best < 0) ? DM : best;
    endfunction

    task automatic tick();
        int g = m_grant, ms = m_master, rem = m_rem;
        bit lk = m_lock, bu = m_burst, rearb = 0;
        bit own_lock = |(hlock & (N'(1) << m_grant));
        int b = int'(hburst);
        if (rst) begin
            g = DM; ms = DM; lk = 0; bu = 0; rem = 0;
        end else if (hready) begin
            ms = m_grant;
            lk = own_lock;
            if (!m_burst) begin
                if (htrans == 2'd2 && b >= 2) begin
                    bu = 1;
                    rem = (4 << ((b - 2) / 2)) - 1;
                end else rearb = 1;
            end else if (htrans == 2'd3) begin
                rem = m_rem - 1;
                if (rem <= 0) begin bu = 0; rem = 0; rearb = 1; end
            end else if (htrans != 2'd1) begin
                bu = 0; rem = 0; rearb = 1;
            end
            if (rearb && !own_lock) g = pick(hbusreq, m_grant);
        end
        @(posedge clk);
        #1;
        m_grant = g; m_master = ms; m_lock = lk; m_burst = bu; m_rem = rem;
    endtask

    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lk,
                         input logic [1:0] tr, input logic [2:0] bst, input logic rdy);
        hbusreq = req; hlock = lk; htrans = tr; hburst = bst; hready = rdy;
    endtask

    task automatic do_reset();
        drive('0, '0, 2'd0, 3'd0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive('0, '0, 2'd0, 3'd0, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (hgrant !== 3'b001) begin n_fail++; $display("FAIL reset_grant: got %b want 001", hgrant); end
        n_cmp++; if (hmaster !== 4'd0) begin n_fail++; $display("FAIL reset_master: got %0d want 0", hmaster); end
        n_cmp++; if (hmastlock !== 1'b0) begin n_fail++; $display("FAIL reset_mastlock: got %b want 0", hmastlock); end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (hgrant !== 3'b001 || hmaster !== 4'd0 || hmastlock !== 1'b0) begin
                n_fail++;
                $display("FAIL park_%0d: got grant %b master %0d lock %b want 001/0/0", k, hgrant, hmaster, hmastlock);
            end
        end
    endtask

    task automatic test_round_robin();
`ifdef ARB_FIXED_PRIORITY_EN
        int exp_seq[5] = '{0, 0, 0, 0, 0};
`else
        int exp_seq[5] = '{1, 2, 0, 1, 2};
`endif
        do_reset();
        drive(3'b111, '0, 2'd2, 3'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (hgrant !== N'(1) << exp_seq[k]) begin
                n_fail++;
                $display("FAIL rr_step_%0d: got %b want %b", k, hgrant, N'(1) << exp_seq[k]);
            end
        end
    endtask

    task automatic test_incr4_protection();
        do_reset();
        drive(3'b010, '0, 2'd0, 3'd0, 1'b1);
        tick();
        drive(3'b110, '0, 2'd2, 3'd3, 1'b1);
        tick();
        n_cmp++; if (hgrant !== 3'b010) begin n_fail++; $display("FAIL incr4_beat1: got %b want 010", hgrant); end
        htrans = 2'd3;
        for (int k = 2; k <= 4; k++) begin
            tick();
            n_cmp++;
            if (hgrant !== ((k == 4) ? 3'b100 : 3'b010)) begin
                n_fail++;
                $display("FAIL incr4_beat%0d: got %b want %b", k, hgrant, (k == 4) ? 3'b100 : 3'b010);
            end
        end
        n_cmp++; if (hmaster !== 4'd1) begin n_fail++; $display("FAIL incr4_master_last: got %0d want 1", hmaster); end
        htrans = 2'd0;
        tick();
        n_cmp++; if (hmaster !== 4'd2) begin n_fail++; $display("FAIL incr4_master_new: got %0d want 2", hmaster); end
    endtask

    task automatic test_incr4_busy_wait();
        logic [1:0] tr[5]  = '{2'd1, 2'd3, 2'd3, 2'd3, 2'd3};
        logic       rdy[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0] eg[5]  = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
        do_reset();
        drive(3'b010, '0, 2'd0, 3'd0, 1'b1);
        tick();
        drive(3'b110, '0, 2'd2, 3'd3, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            htrans = tr[k];
            hready = rdy[k];
            tick();
            n_cmp++;
            if (hgrant !== eg[k]) begin
                n_fail++;
                $display("FAIL incr4_wait_%0d: got %b want %b", k, hgrant, eg[k]);
            end
        end
    endtask

    task automatic test_early_termination();
`ifdef ARB_FIXED_PRIORITY_EN
        logic [2:0] want = 3'b001;
`else
        logic [2:0] want = 3'b010;
`endif
        do_reset();
        drive(3'b011, '0, 2'd2, 3'd4, 1'b1);
        tick();
        htrans = 2'd3;
        tick();
        tick();
        n_cmp++; if (hgrant !== 3'b001) begin n_fail++; $display("FAIL wrap8_hold: got %b want 001", hgrant); end
        htrans = 2'd0;
        tick();
        n_cmp++; if (hgrant !== want) begin n_fail++; $display("FAIL wrap8_abort: got %b want %b", hgrant, want); end
    endtask

    task automatic test_locked();
        do_reset();
        drive(3'b100, '0, 2'd0, 3'd0, 1'b1);
        tick();
        drive(3'b111, 3'b100, 2'd2, 3'd0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++;
            if (hgrant !== 3'b100 || hmastlock !== 1'b1) begin
                n_fail++;
                $display("FAIL lock_%0d: got grant %b mastlock %b want 100/1", k, hgrant, hmastlock);
            end
        end
        hlock = '0;
        tick();
        n_cmp++; if (hgrant !== 3'b001) begin n_fail++; $display("FAIL lock_release: got %b want 001", hgrant); end
        n_cmp++; if (hmastlock !== 1'b0) begin n_fail++; $display("FAIL lock_release_ml: got %b want 0", hmastlock); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        drive(3'b010, '0, 2'd0, 3'd0, 1'b1);
        tick();
        drive(3'b010, '0, 2'd2, 3'd7, 1'b1);
        tick();
        htrans = 2'd3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (hgrant !== 3'b001 || hmaster !== 4'd0 || hmastlock !== 1'b0) begin
            n_fail++;
            $display("FAIL midburst_reset: got grant %b master %0d lock %b want 001/0/0", hgrant, hmaster, hmastlock);
        end
        htrans = 2'd0;
        tick();
        n_cmp++; if (hgrant !== 3'b010) begin n_fail++; $display("FAIL midburst_rearb: got %b want 010", hgrant); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            hbusreq = N'($urandom);
            hlock   = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            htrans  = (m_burst && $urandom_range(0, 9) < 7) ? 2'd3 : 2'($urandom);
            hburst  = 3'($urandom);
            hready  = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 99) == 0);
            tick();
            n_cmp++;
            if (hgrant !== N'(1) << m_grant || hmaster !== 4'(m_master) || hmastlock !== m_lock) begin
                n_fail++;
                $display("FAIL random_%0d: got grant %b master %0d lock %b want %b/%0d/%b",
                         k, hgrant, hmaster, hmastlock, N'(1) << m_grant, m_master, m_lock);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_grant = DM; m_master = DM; m_rem = 0; m_lock = 0; m_burst = 0;
        test_reset();
        test_round_robin();
        test_incr4_protection();
        test_incr4_busy_wait();
        test_early_termination();
        test_locked();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
